// File: rtl/flow_control.sv
`default_nettype none
// ============================================================================
//  Module   : flow_control
//  Purpose  : Program-counter sequencer sitting between the ALU and
//             instruction fetch. Latches ALU flags into the {C,N,Z} status
//             word consumed by the jump decoder, advances or loads the PC
//             from the resulting jump decision, inserts a one-cycle fetch
//             bubble after taken jumps, and handles halt/resume.
//  Ports    :
//    i_clk          clock, rising edge
//    i_rst_n        asynchronous active-low reset
//    i_flag_we      ALU result valid, latch new flags
//    i_alu_result   ALU result used for Z/N
//    i_alu_carry    ALU carry-out used for C
//    i_branch       current instruction is jump-class
//    i_jump         jump decision from the decoder
//    i_jump_addr    jump target
//    i_halt         current instruction is HALT
//    i_resume       leave HALT
//    i_stall        freeze state for this cycle
//    o_status       {C,N,Z} flag register
//    o_pc           address being fetched
//    o_fetch_valid  o_pc is a real fetch this cycle
//    o_flush        one-cycle pulse, discard in-flight instruction
//    o_halted       block is in HALT
//  Revision : 1.0  initial release
// ============================================================================
module flow_control #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flag_we,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_carry,
    input  logic              i_branch,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_addr,
    input  logic              i_halt,
    input  logic              i_resume,
    input  logic              i_stall,
    output logic [2:0]        o_status,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_fetch_valid,
    output logic              o_flush,
    output logic              o_halted
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [2:0]        r_status;
    logic [2:0]        w_status_nxt;
    logic [2:0]        w_flags_new;
    logic              r_fetch_valid;
    logic              w_fetch_valid_nxt;
    logic              r_flush;
    logic              w_flush_nxt;
    logic              r_halted;
    logic              w_halted_nxt;

    // Natural wrap at 2^ADDR_W
    assign w_pc_inc    = r_pc + ADDR_W'(1);

    // Bit order: [0]=Z, [1]=N, [2]=C
    assign w_flags_new = {i_alu_carry, i_alu_result[DATA_W-1], (i_alu_result == '0)};

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_status_nxt      = r_status;
        w_fetch_valid_nxt = r_fetch_valid;
        w_flush_nxt       = 1'b0;
        w_halted_nxt      = r_halted;

        case (r_state)
            S_BOOT: begin
                w_state_nxt       = S_RUN;
                w_pc_nxt          = '0;
                w_fetch_valid_nxt = 1'b1;
                w_halted_nxt      = 1'b0;
            end

            S_RUN: begin
                if (!i_stall) begin
                    // Flags also update on a halt or branch cycle; the jump
                    // decision of this cycle was made on the old r_status.
                    if (i_flag_we) begin
                        w_status_nxt = w_flags_new;
                    end

                    if (i_halt) begin
                        w_pc_nxt          = w_pc_inc;
                        w_state_nxt       = S_HALT;
                        w_halted_nxt      = 1'b1;
                        w_fetch_valid_nxt = 1'b0;
                    end else if (i_branch && i_jump) begin
                        w_pc_nxt          = i_jump_addr;
                        w_flush_nxt       = 1'b1;
                        w_state_nxt       = S_FLUSH;
                        w_fetch_valid_nxt = 1'b0;
                    end else begin
                        w_pc_nxt          = w_pc_inc;
                    end
                end
            end

            // Bubble cycle: PC already holds the target, so just refetch it
            S_FLUSH: begin
                w_state_nxt       = S_RUN;
                w_fetch_valid_nxt = 1'b1;
            end

            S_HALT: begin
                if (!i_stall && i_resume) begin
                    w_state_nxt       = S_RUN;
                    w_fetch_valid_nxt = 1'b1;
                    w_halted_nxt      = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_BOOT;
            r_pc          <= '0;
            r_status      <= 3'b000;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_status      <= w_status_nxt;
            r_fetch_valid <= w_fetch_valid_nxt;
            r_flush       <= w_flush_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    assign o_status      = r_status;
    assign o_pc          = r_pc;
    assign o_fetch_valid = r_fetch_valid;
    assign o_flush       = r_flush;
    assign o_halted      = r_halted;

endmodule
`default_nettype wire
